ppa_pipe: RTL
=============

Name: ppa_pipe

Overview:
- Parametrised, pipelined Brent-Kung parallel-prefix adder/subtractor. It is the successor to the fixed 16-bit combinational prefix adder.
- Adds configurable width, configurable pipeline depth, a subtract mode, a signed overflow flag and a valid/ready handshake on both sides.
- Sits in the FIR datapath as the accumulate/tap-sum adder. Backpressure from the downstream accumulator register is honoured.

Parameters:
- WIDTH, 16, operand/sum width in bits. Power of two, 4..64.
- STAGES, 2, number of register stages, 1..2*log2(WIDTH). Equals latency in cycles from accept to out_valid.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  adder can accept this cycle.
- add_1  in  WIDTH  operand A.
- add_2  in  WIDTH  operand B.
- c_in  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+c_in; 1 = A-B-c_in.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- c_out  out  1  carry-out. In subtract mode 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear; out_valid=0, sum=0, c_out=0, ovf=0. in_ready=1 from the first cycle after release.
- Operand conditioning at accept:
  - B' = sub ? ~add_2 : add_2.
  - cin' = c_in ^ sub.
  - Core computes A + B' + cin' as a WIDTH+1-bit result; sum = low WIDTH bits, c_out = bit WIDTH.
- ovf = (A[msb] == B'[msb]) && (sum[msb] != A[msb]).
- Prefix network:
  - g_i = a&b', p_i = a^b'.
  - Carry-in folded in as generate at position -1.
  - Brent-Kung tree: log2(WIDTH) up-sweep levels, log2(WIDTH)-1 down-sweep levels, then sum_i = p_i ^ c_i.
  - The 2*log2(WIDTH) logic levels (prefix levels plus final XOR) are split across STAGES registers as evenly as possible. Any extra levels go to the earliest stages.
  - Stage 1 registers the conditioned operands and carry-in plus the first level group.
- Handshake:
  - Accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - Per-stage flow control: stage k advances when !valid_k || ready_{k+1}. The last stage's ready is out_ready, and in_ready = stage-1 ready.
  - Bubbles collapse; the pipeline holds up to STAGES results.
- Timing and ordering:
  - With out_ready held high: one result per cycle; the result appears STAGES cycles after accept.
  - Results leave in accept order; none are dropped or duplicated.
- Stall: while out_valid && !out_ready, sum/c_out/ovf hold stable. A full pipeline drives in_ready=0.
- Simultaneous accept and output transfer on a full pipeline is legal. The pipeline shifts and in_ready stays 1.
- Input data is not captured when in_valid=0. Stage data registers may hold stale values when their valid bit is 0.
- Reset mid-operation: all in-flight results are discarded and none emerges after release.
- Wrap-around is silent in add mode (c_out=1, sum modulo 2^WIDTH) unless the optional feature is enabled.

Optional Feature:
- Macro PPA_PIPE_SAT_EN.
- Defined: when ovf=1, sum saturates to the signed limit. Positive overflow gives 0111..1; negative overflow gives 1000..0. ovf is still reported; c_out is unaffected. Saturation is applied in the final stage with no extra latency.
- Undefined: sum wraps modulo 2^WIDTH. No saturation logic is present.

Test Plan (WIDTH=16, STAGES=2 unless noted):
- Add, out_ready=1: A=4322, B=7656, c_in=1, sub=0 -> 2 cycles later sum=11979, c_out=0, ovf=0. Then A=987, B=71, c_in=0 -> sum=1058 on the next cycle (back-to-back, 1/cycle).
- Carry wrap: A=65534, B=1, c_in=1 -> sum=0, c_out=1, ovf=0. With c_in=0 -> sum=65535, c_out=0.
- Subtract: A=987, B=71, sub=1, c_in=0 -> sum=916, c_out=1. Then A=71, B=987 -> sum=64620, c_out=0. Then A=987, B=71, c_in=1 -> sum=915.
- Overflow: A=0x7FFF, B=0x0001, sub=0 -> ovf=1; sum=0x8000, or 0x7FFF with PPA_PIPE_SAT_EN. A=0x8000, B=0x0001, sub=1 -> ovf=1; sum=0x7FFF, or 0x8000 with saturation.
- Backpressure: out_ready=0, present 3 valid operand sets -> in_ready=0 after 2 accepts. Raising out_ready drains the results in order with no loss. A third set held on the input is accepted on the first drain cycle.
- Reset mid-flight: 2 results in the pipe, pull rst_n low for 1 cycle -> out_valid=0 immediately and no stale result afterwards. Repeat the first scenario with STAGES=1 and with WIDTH=32, STAGES=4 -> latency 1 and 4 respectively, matching results.

Source files
------------

// File: rtl/ppa_pipe_if.sv
// Handshake/operand bundle for ppa_pipe: operand side (in_*) and result side (out_*).
// The adder side uses the slave modport; the producer/consumer side uses master.
interface ppa_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] add_1;
  logic [WIDTH-1:0] add_2;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, add_1, add_2, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, add_1, add_2, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/ppa_pipe.sv
// Pipelined Brent-Kung prefix adder/subtractor with per-stage valid/ready flow control.
// Optional macro PPA_PIPE_SAT_EN saturates the sum to the signed limit on overflow.
module ppa_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input logic      clk,
  input logic      rst_n,
  ppa_pipe_if.slave bus
);

  localparam int LOG    = $clog2(WIDTH);
  localparam int LEVELS = 2 * LOG;
  localparam int BASE   = LEVELS / STAGES;
  localparam int EXTRA  = LEVELS % STAGES;

  // g/gp are the running group generate/propagate; p is the bitwise propagate kept for the sum XOR.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] gp;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] sum;
    logic             cin;
    logic             a_msb;
    logic             c_out;
    logic             ovf;
  } stage_t;

  function automatic stage_t condition(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                       logic ci, logic s);
    stage_t           r;
    logic [WIDTH-1:0] bb;
    logic             cc;
    bb      = s ? ~b : b;
    cc      = ci ^ s;
    r       = '0;
    r.p     = a ^ bb;
    r.gp    = a ^ bb;
    r.g     = a & bb;
    // Carry-in enters as a generate below bit 0, so every prefix G already includes it.
    r.g[0]  = r.g[0] | (r.p[0] & cc);
    r.cin   = cc;
    r.a_msb = a[WIDTH-1];
    return r;
  endfunction

  // Levels 0..LOG-1 are the up-sweep, then LOG-1 down-sweep levels, then the sum XOR.
  function automatic stage_t apply_level(stage_t s, int lvl);
    stage_t r;
    int     d;
    r = s;
    if (lvl < LOG) begin
      d = 1 << lvl;
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (2 * d)) == 0) begin
          r.g[i]  = s.g[i] | (s.gp[i] & s.g[i-d]);
          r.gp[i] = s.gp[i] & s.gp[i-d];
        end
      end
    end else if (lvl < LEVELS - 1) begin
      d = 1 << (LEVELS - 2 - lvl);
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= 2 * d && ((i + 1) % (2 * d)) == d) begin
          r.g[i]  = s.g[i] | (s.gp[i] & s.g[i-d]);
          r.gp[i] = s.gp[i] & s.gp[i-d];
        end
      end
    end else begin
      r.sum   = s.p ^ {s.g[WIDTH-2:0], s.cin};
      r.c_out = s.g[WIDTH-1];
      r.ovf   = !s.p[WIDTH-1] && (r.sum[WIDTH-1] != s.a_msb);
`ifdef PPA_PIPE_SAT_EN
      if (r.ovf) r.sum = {s.a_msb, {(WIDTH-1){~s.a_msb}}};
`endif
    end
    return r;
  endfunction

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] ready;
  stage_t            data_q [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Earlier stages absorb the remainder when levels do not divide evenly.
    localparam int FIRST = k * BASE + ((k < EXTRA) ? k : EXTRA);
    localparam int CNT   = BASE + ((k < EXTRA) ? 1 : 0);

    stage_t d_in;
    stage_t d_next;
    stage_t data_r;
    logic   valid_r;
    logic   prev_valid;

    if (k == 0) begin : g_head
      assign d_in       = condition(bus.add_1, bus.add_2, bus.c_in, bus.sub);
      assign prev_valid = bus.in_valid;
    end else begin : g_body
      assign d_in       = data_q[k-1];
      assign prev_valid = valid_q[k-1];
    end

    // A stage can load when it or every stage after it has room, or the consumer drains.
    assign ready[k] = bus.out_ready | ~(&valid_q[STAGES-1:k]);

    // NOTE: blocking assignment chains the levels of this group within one cycle.
    always_comb begin
      d_next = d_in;
      for (int l = 0; l < CNT; l++) d_next = apply_level(d_next, FIRST + l);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        // NOTE: data is reset too so the outputs read zero right after reset.
        data_r  <= '0;
      end else if (ready[k]) begin
        valid_r <= prev_valid;
        if (prev_valid) data_r <= d_next;
      end
    end

    assign valid_q[k] = valid_r;
    assign data_q[k]  = data_r;
  end

  assign bus.in_ready  = ready[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = data_q[STAGES-1].sum;
  assign bus.c_out     = data_q[STAGES-1].c_out;
  assign bus.ovf       = data_q[STAGES-1].ovf;

endmodule
